branch_pc_unit: RTL and testbench

Consumer end of the branch-condition path. Takes the branch-taken flag produced by the branch comparator, together with the branch target and any unconditional jump, and owns the 16-bit program counter. On a redirect it loads the new PC, squashes wrong-path instructions with a timed flush pulse, and keeps saturating taken and not-taken statistics. It sits between the execute-stage comparator and the fetch stage.

---
 rtl/branch_pc_unit.sv | 114 +++++++++++
 tb/tb_branch_pc_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter owner for the fetch stage: applies branch/jump redirects, times the
// wrong-path flush window and keeps saturating taken / not-taken branch statistics.
module branch_pc_unit #(
    parameter int                     PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
    parameter int                     FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_valid,
    input  logic                taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic                redirect,
    output logic [PC_WIDTH-1:0] taken_count,
    output logic [PC_WIDTH-1:0] not_taken_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    // Down-counter holds remaining flush cycles after the current one.
    localparam logic [2:0]          FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);

    state_t                state_q, state_d;
    logic [2:0]            fcnt_q, fcnt_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  flush_q, flush_d;
    logic                  redirect_q, redirect_d;
    logic [PC_WIDTH-1:0]   tc_q, tc_d;
    logic [PC_WIDTH-1:0]   ntc_q, ntc_d;
    logic [PC_WIDTH-1:0]   pc_seq;

    assign pc_seq = stall ? pc_q : pc_q + PC_ONE;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_d       = pc_q;
        flush_d    = flush_q;
        redirect_d = 1'b0;
        tc_d       = tc_q;
        ntc_d      = ntc_q;
        case (state_q)
            RUN: begin
                if (branch_valid && taken && tc_q != CNT_MAX)
                    tc_d = tc_q + PC_ONE;
                if (branch_valid && !taken && ntc_q != CNT_MAX)
                    ntc_d = ntc_q + PC_ONE;
                // Redirects win over stall; a not-taken branch lets a younger jump through.
                if (branch_valid && taken) begin
                    pc_d       = branch_target;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    fcnt_d     = FLUSH_LAST;
                    state_d    = FLUSH;
                end else if (jump_valid) begin
                    pc_d       = jump_target;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    fcnt_d     = FLUSH_LAST;
                    state_d    = FLUSH;
                end else begin
                    pc_d = pc_seq;
                end
            end
            FLUSH: begin
                pc_d = pc_seq;
                if (fcnt_q == 3'd0) begin
                    flush_d = 1'b0;
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fcnt_q     <= 3'd0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            tc_q       <= '0;
            ntc_q      <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            tc_q       <= tc_d;
            ntc_q      <= ntc_d;
        end
    end

    assign pc              = pc_q;
    assign flush           = flush_q;
    assign redirect        = redirect_q;
    assign taken_count     = tc_q;
    assign not_taken_count = ntc_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a cycle model tracks the expected outputs and is
// compared every negedge, with literal expectations pinning key points of the sequence.
module tb_branch_pc_unit;

    localparam int PC_WIDTH = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int MASK = 32'h0000FFFF;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stall = 1'b0;
    logic                branch_valid = 1'b0;
    logic                taken = 1'b0;
    logic [PC_WIDTH-1:0] branch_target = '0;
    logic                jump_valid = 1'b0;
    logic [PC_WIDTH-1:0] jump_target = '0;
    logic [PC_WIDTH-1:0] pc;
    logic                flush;
    logic                redirect;
    logic [PC_WIDTH-1:0] taken_count;
    logic [PC_WIDTH-1:0] not_taken_count;

    int checks = 0;
    int failures = 0;

    branch_pc_unit #(
        .PC_WIDTH(PC_WIDTH), .RESET_PC(16'h0000), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_valid(branch_valid), .taken(taken), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .pc(pc), .flush(flush), .redirect(redirect),
        .taken_count(taken_count), .not_taken_count(not_taken_count)
    );

    always #5 clk = ~clk;

    // Model: remaining flush cycles as a plain integer, counters as clamped integers.
    int m_pc, m_left, m_tc, m_nt;
    bit m_redir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 0; m_left <= 0; m_tc <= 0; m_nt <= 0; m_redir <= 1'b0;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_redir <= 1'b0;
            m_pc    <= stall ? m_pc : ((m_pc + 1) & MASK);
        end else begin
            if (branch_valid && taken)  m_tc <= (m_tc < MASK) ? m_tc + 1 : m_tc;
            if (branch_valid && !taken) m_nt <= (m_nt < MASK) ? m_nt + 1 : m_nt;
            if (branch_valid && taken) begin
                m_pc <= branch_target; m_redir <= 1'b1; m_left <= FLUSH_CYCLES;
            end else if (jump_valid) begin
                m_pc <= jump_target; m_redir <= 1'b1; m_left <= FLUSH_CYCLES;
            end else begin
                m_redir <= 1'b0;
                m_pc    <= stall ? m_pc : ((m_pc + 1) & MASK);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_pc", int'(pc), m_pc);
            chk("model_flush", int'(flush), int'(m_left > 0));
            chk("model_redirect", int'(redirect), int'(m_redir));
            chk("model_taken_count", int'(taken_count), m_tc);
            chk("model_not_taken_count", int'(not_taken_count), m_nt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("reset_pc", int'(pc), 0);
        chk("reset_flush", int'(flush), 0);
        chk("reset_redirect", int'(redirect), 0);
        chk("reset_counts", int'(taken_count) + int'(not_taken_count), 0);
        #9 rst_n = 1'b1;
        // taken without branch_valid must be ignored
        taken = 1'b1;
        repeat (4) tick();
        chk("seq_pc4", int'(pc), 4);
        tick();
        chk("seq_pc5", int'(pc), 5);
        chk("seq_tc0", int'(taken_count), 0);

        branch_valid = 1'b1; taken = 1'b1; branch_target = 16'h0040;
        tick();
        chk("br_pc", int'(pc), 16'h0040);
        chk("br_redirect", int'(redirect), 1);
        chk("br_flush", int'(flush), 1);
        chk("br_tc", int'(taken_count), 1);
        branch_target = 16'h0100;
        tick();
        chk("fl_pc", int'(pc), 16'h0041);
        chk("fl_flush", int'(flush), 1);
        chk("fl_redirect", int'(redirect), 0);
        tick();
        chk("fl_end_pc", int'(pc), 16'h0042);
        chk("fl_end_flush", int'(flush), 0);
        chk("fl_end_tc", int'(taken_count), 1);

        taken = 1'b0; jump_valid = 1'b1; jump_target = 16'h0200; stall = 1'b1;
        tick();
        chk("jmp_pc", int'(pc), 16'h0200);
        chk("jmp_redirect", int'(redirect), 1);
        chk("jmp_ntc", int'(not_taken_count), 1);
        chk("jmp_tc", int'(taken_count), 1);
        branch_valid = 1'b0; jump_valid = 1'b0;
        tick();
        chk("jmp_stall_pc", int'(pc), 16'h0200);
        stall = 1'b0;
        tick();
        chk("jmp_end_pc", int'(pc), 16'h0201);
        chk("jmp_end_flush", int'(flush), 0);

        jump_valid = 1'b1; jump_target = 16'hFFFE;
        tick();
        jump_valid = 1'b0;
        chk("wrap_start", int'(pc), 16'hFFFE);
        stall = 1'b0; tick();
        chk("wrap_ffff", int'(pc), 16'hFFFF);
        stall = 1'b1; tick();
        chk("wrap_hold", int'(pc), 16'hFFFF);
        stall = 1'b0; tick();
        chk("wrap_zero", int'(pc), 16'h0000);

        branch_valid = 1'b1; taken = 1'b0;
        repeat (65537) tick();
        chk("sat_ntc", int'(not_taken_count), 16'hFFFF);
        chk("sat_tc", int'(taken_count), 1);
        branch_valid = 1'b0;
        jump_valid = 1'b1; jump_target = 16'h1234;
        tick();
        jump_valid = 1'b0;
        chk("pre_rst_flush", int'(flush), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", int'(pc), 0);
        chk("arst_flush", int'(flush), 0);
        chk("arst_redirect", int'(redirect), 0);
        chk("arst_ntc", int'(not_taken_count), 0);
        chk("arst_tc", int'(taken_count), 0);
        #4 rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_pc", int'(pc), 3);
        chk("post_rst_flush", int'(flush), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
